mvm_ctrl: RTL and testbench

//  Control unit for the M x M matrix-vector multiplier (y = A*x) datapath.

---
 rtl/mvm_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mvm_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mvm_ctrl.sv
// Control unit for an M x M matrix-vector multiplier (y = A*x).
// Sequences A/x loads, issues MAC reads with tagged tokens, writes y and streams it out.
module mvm_ctrl #(
  parameter int unsigned M    = 12,
  parameter int unsigned PIPE = 2,
  parameter int unsigned AW   = $clog2(M * M),
  parameter int unsigned XW   = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          loadMatrix,
  input  logic          loadVector,
  input  logic          start,
  output logic          done,
  output logic          a_wr_en,
  output logic [AW-1:0] a_wr_addr,
  output logic          x_wr_en,
  output logic [XW-1:0] x_wr_addr,
  output logic [AW-1:0] a_rd_addr,
  output logic [XW-1:0] x_rd_addr,
  output logic          acc_en,
  output logic          acc_first,
  output logic          y_wr_en,
  output logic [XW-1:0] y_wr_addr,
  output logic [XW-1:0] out_sel
);

  localparam int unsigned NumA    = M * M;
  localparam int unsigned DoneCnt = NumA + PIPE + 1;
  localparam int unsigned CW      = $clog2(DoneCnt + 1);

  typedef enum logic [2:0] {StIdle, StLoadA, StLoadX, StCompute, StOutput} state_e;

  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [XW-1:0] row;
  } tok_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] col_q, col_d, row_q, row_d;
  logic [XW-1:0] out_sel_q, out_sel_d;
  logic          y_wr_en_q;
  logic [XW-1:0] y_wr_addr_q;
  tok_t          tok_q [PIPE];
  tok_t          tok_in;
  logic          ready, last_cycle, issue;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    col_d      = col_q;
    row_d      = row_q;
    out_sel_d  = out_sel_q;
    ready      = 1'b0;
    last_cycle = 1'b0;
    issue      = 1'b0;
    done       = 1'b0;
    a_wr_en    = 1'b0;
    a_wr_addr  = '0;
    x_wr_en    = 1'b0;
    x_wr_addr  = '0;
    a_rd_addr  = '0;
    x_rd_addr  = '0;
    out_sel    = out_sel_q;
    tok_in     = '0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        cnt_d = '0;
      end
      StLoadA: begin
        a_wr_en    = 1'b1;
        a_wr_addr  = cnt_q[AW-1:0];
        last_cycle = (cnt_q == CW'(NumA - 1));
      end
      StLoadX: begin
        x_wr_en    = 1'b1;
        x_wr_addr  = cnt_q[XW-1:0];
        last_cycle = (cnt_q == CW'(M - 1));
      end
      StCompute: begin
        issue = (cnt_q < CW'(NumA));
        if (issue) begin
          a_rd_addr    = cnt_q[AW-1:0];
          x_rd_addr    = col_q;
          tok_in.valid = 1'b1;
          tok_in.first = (col_q == '0);
          tok_in.last  = (col_q == XW'(M - 1));
          tok_in.row   = row_q;
          if (col_q == XW'(M - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        // Issue phase ends at NumA; the extra PIPE+1 cycles drain the MAC pipe.
        if (cnt_q == CW'(DoneCnt)) begin
          done    = 1'b1;
          state_d = StOutput;
          cnt_d   = '0;
        end
      end
      StOutput: begin
        out_sel    = cnt_q[XW-1:0];
        out_sel_d  = cnt_q[XW-1:0];
        last_cycle = (cnt_q == CW'(M - 1));
      end
      default: state_d = StIdle;
    endcase

    if (last_cycle) begin
      ready   = 1'b1;
      state_d = StIdle;
      cnt_d   = '0;
    end

    if (ready) begin
      if (loadMatrix) begin
        state_d = StLoadA;
        cnt_d   = '0;
      end else if (loadVector) begin
        state_d = StLoadX;
        cnt_d   = '0;
      end else if (start) begin
        state_d = StCompute;
        cnt_d   = '0;
        col_d   = '0;
        row_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_sel_q   <= '0;
      y_wr_en_q   <= 1'b0;
      y_wr_addr_q <= '0;
      for (int i = 0; i < PIPE; i++) tok_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_sel_q   <= out_sel_d;
      tok_q[0]    <= tok_in;
      for (int i = 1; i < PIPE; i++) tok_q[i] <= tok_q[i-1];
      // Accumulator holds the finished row one cycle after its last product.
      y_wr_en_q   <= tok_q[PIPE-1].valid & tok_q[PIPE-1].last;
      y_wr_addr_q <= tok_q[PIPE-1].last ? tok_q[PIPE-1].row : '0;
    end
  end

  assign acc_en    = tok_q[PIPE-1].valid;
  assign acc_first = tok_q[PIPE-1].valid & tok_q[PIPE-1].first;
  assign y_wr_en   = y_wr_en_q;
  assign y_wr_addr = y_wr_addr_q;

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed bench for mvm_ctrl with a behavioural datapath (A/x RAMs, mult reg, acc, y regs).
module tb_mvm_ctrl;

  localparam int M    = 12;
  localparam int PIPE = 2;
  localparam int AW   = $clog2(M * M);
  localparam int XW   = $clog2(M);

  logic          clk = 1'b0;
  logic          reset, loadMatrix, loadVector, start;
  logic          done, a_wr_en, x_wr_en, acc_en, acc_first, y_wr_en;
  logic [AW-1:0] a_wr_addr, a_rd_addr;
  logic [XW-1:0] x_wr_addr, x_rd_addr, y_wr_addr, out_sel;

  logic [15:0] data_in, data_out;
  logic [15:0] amem [M*M];
  logic [15:0] xmem [M];
  logic [15:0] ymem [M];
  logic [15:0] a_rd_q, x_rd_q, prod_q, acc;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  mvm_ctrl #(.M(M), .PIPE(PIPE)) dut (
    .clk        (clk),
    .reset      (reset),
    .loadMatrix (loadMatrix),
    .loadVector (loadVector),
    .start      (start),
    .done       (done),
    .a_wr_en    (a_wr_en),
    .a_wr_addr  (a_wr_addr),
    .x_wr_en    (x_wr_en),
    .x_wr_addr  (x_wr_addr),
    .a_rd_addr  (a_rd_addr),
    .x_rd_addr  (x_rd_addr),
    .acc_en     (acc_en),
    .acc_first  (acc_first),
    .y_wr_en    (y_wr_en),
    .y_wr_addr  (y_wr_addr),
    .out_sel    (out_sel)
  );

  // Datapath model: RAM read reg then multiply reg gives PIPE=2.
  always @(posedge clk) begin
    if (a_wr_en) amem[a_wr_addr] <= data_in;
    if (x_wr_en) xmem[x_wr_addr] <= data_in;
    a_rd_q <= amem[a_rd_addr];
    x_rd_q <= xmem[x_rd_addr];
    prod_q <= a_rd_q * x_rd_q;
    if (acc_en) acc <= acc_first ? prod_q : acc + prod_q;
    if (y_wr_en) ymem[y_wr_addr] <= acc;
    if (done) done_cnt <= done_cnt + 1;
  end

  assign data_out = ymem[out_sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_wr_en"},   32'(a_wr_en),   0);
    chk({tag, "_a_wr_addr"}, 32'(a_wr_addr), 0);
    chk({tag, "_x_wr_en"},   32'(x_wr_en),   0);
    chk({tag, "_x_wr_addr"}, 32'(x_wr_addr), 0);
    chk({tag, "_a_rd_addr"}, 32'(a_rd_addr), 0);
    chk({tag, "_x_rd_addr"}, 32'(x_rd_addr), 0);
    chk({tag, "_acc_en"},    32'(acc_en),    0);
    chk({tag, "_acc_first"}, 32'(acc_first), 0);
    chk({tag, "_y_wr_en"},   32'(y_wr_en),   0);
    chk({tag, "_y_wr_addr"}, 32'(y_wr_addr), 0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_out_sel"},   32'(out_sel),   0);
  endtask

  initial begin
    reset      = 1'b1;
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    start      = 1'b0;
    data_in    = '0;
    cyc();
    cyc();
    chk_all_zero("reset");
    reset = 1'b0;

    // Load A = identity.
    loadMatrix = 1'b1;
    cyc();
    loadMatrix = 1'b0;
    for (int k = 0; k < M * M; k++) begin
      data_in = (k / M == k % M) ? 16'd1 : 16'd0;
      chk("loada_en", 32'(a_wr_en), 1);
      chk("loada_addr", 32'(a_wr_addr), 32'(k));
      cyc();
    end
    chk("loada_end_en", 32'(a_wr_en), 0);
    chk("loada_end_xen", 32'(x_wr_en), 0);

    // Load x = 1..M, start in the final load cycle.
    loadVector = 1'b1;
    cyc();
    loadVector = 1'b0;
    for (int k = 0; k < M; k++) begin
      data_in = 16'(k + 1);
      chk("loadx_en", 32'(x_wr_en), 1);
      chk("loadx_addr", 32'(x_wr_addr), 32'(k));
      if (k == M - 1) start = 1'b1;
      cyc();
    end
    start = 1'b0;

    // Compute + output, with ignored loadVector (cycle 50) and start (cycle 150).
    for (int c = 0; c < 160; c++) begin
      loadVector = (c == 50);
      start      = (c == 150);
      chk("cmp_done", 32'(done), 32'(c == 147));
      chk("cmp_y_wr_en", 32'(y_wr_en), 32'(c >= 14 && c <= 146 && (c - 14) % M == 0));
      if (c >= 14 && c <= 146 && (c - 14) % M == 0)
        chk("cmp_y_wr_addr", 32'(y_wr_addr), 32'((c - 14) / M));
      chk("cmp_acc_en", 32'(acc_en), 32'(c >= 2 && c < 146));
      if (c >= 2 && c < 146)
        chk("cmp_acc_first", 32'(acc_first), 32'((c - 2) % M == 0));
      if (c < M * M) begin
        chk("cmp_a_rd", 32'(a_rd_addr), 32'(c));
        chk("cmp_x_rd", 32'(x_rd_addr), 32'(c % M));
      end
      chk("cmp_x_wr_en", 32'(x_wr_en), 0);
      if (c >= 148) begin
        chk("out_sel", 32'(out_sel), 32'(c - 148));
        chk("out_data", 32'(data_out), 32'(c - 147));
      end
      cyc();
    end
    loadVector = 1'b0;
    start      = 1'b0;
    chk("post_done_cnt", 32'(done_cnt), 1);
    chk("post_out_sel_hold", 32'(out_sel), 11);
    chk("post_a_rd", 32'(a_rd_addr), 0);

    // loadMatrix + start together: matrix load wins, start dropped.
    loadMatrix = 1'b1;
    start      = 1'b1;
    cyc();
    loadMatrix = 1'b0;
    start      = 1'b0;
    for (int k = 0; k < M * M; k++) begin
      data_in = (k / M == k % M) ? 16'd1 : 16'd0;
      chk("prio_a_wr_en", 32'(a_wr_en), 1);
      chk("prio_done", 32'(done), 0);
      cyc();
    end
    for (int k = 0; k < 5; k++) begin
      chk("prio_idle_acc", 32'(acc_en), 0);
      chk("prio_idle_a_rd", 32'(a_rd_addr), 0);
      cyc();
    end
    chk("prio_done_cnt", 32'(done_cnt), 1);

    // Reset at compute cycle 60 aborts; a fresh start completes normally.
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c <= 60; c++) begin
      chk("abort_done", 32'(done), 0);
      if (c == 60) reset = 1'b1;
      cyc();
    end
    chk_all_zero("abort");
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("abort_idle_done", 32'(done), 0);
      chk("abort_idle_acc", 32'(acc_en), 0);
      chk("abort_idle_y", 32'(y_wr_en), 0);
      cyc();
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c <= 150; c++) begin
      chk("rerun_done", 32'(done), 32'(c == 147));
      cyc();
    end
    chk("rerun_done_cnt", 32'(done_cnt), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
